// File: rtl/pending_priority_encoder_if.sv
// pending_priority_encoder_if: request/grant bundle between a producer/consumer
// (master) and the pending priority encoder (slave). W is derived from N.
interface pending_priority_encoder_if #(
  parameter int N = 8
);
  localparam int W = $clog2(N);

  logic [N-1:0] req_in;
  logic         clr_all;
  logic [W-1:0] enc_out;
  logic         enc_valid;
  logic         enc_ready;
  logic [N-1:0] pending;
  logic [W:0]   pend_count;
  logic         overflow;

  modport master (
    output req_in, clr_all, enc_ready,
    input  enc_out, enc_valid, pending, pend_count, overflow
  );

  modport slave (
    input  req_in, clr_all, enc_ready,
    output enc_out, enc_valid, pending, pend_count, overflow
  );
endinterface

// File: rtl/pending_priority_encoder.sv
// pending_priority_encoder: sticky pending register over N request lines,
// presenting one pending index at a time over a valid/ready handshake.
// Optional macro PENC_ROUND_ROBIN_EN compiles in a rotating start pointer;
// without it the lowest pending index always wins.
// All outputs are registered: they are computed from the next-state values so
// they equal a combinational decode of the current pending/pointer state.
module pending_priority_encoder #(
  parameter int N = 8
) (
  input logic                           clk,
  input logic                           rst,
  pending_priority_encoder_if.slave     bus
);
  localparam int W = $clog2(N);

  logic [N-1:0] pending_r;
  logic [N-1:0] pending_next_s;
  logic [N-1:0] grant_mask_s;
  logic [W-1:0] enc_out_r;
  logic         enc_valid_r;
  logic [W:0]   pend_count_r;
  logic         overflow_r;
  logic         overflow_next_s;
  logic         handshake_s;
  logic [W-1:0] ptr_next_s;

  // First set bit at or above start; if none, first set bit from index 0.
  // Returns 0 when vec is empty.
  function automatic logic [W-1:0] select_idx(input logic [N-1:0] vec,
                                              input logic [W-1:0] start);
    logic [W-1:0] idx_hi;
    logic [W-1:0] idx_lo;
    logic         found_hi;
    idx_hi   = {W{1'b0}};
    idx_lo   = {W{1'b0}};
    found_hi = 1'b0;
    // Descending scan so the last hit recorded is the lowest index.
    for (int i = N - 1; i >= 0; i--) begin
      idx_lo   = vec[i] ? W'(i) : idx_lo;
      idx_hi   = (vec[i] && (i >= int'(start))) ? W'(i) : idx_hi;
      found_hi = (vec[i] && (i >= int'(start))) ? 1'b1 : found_hi;
    end
    return found_hi ? idx_hi : idx_lo;
  endfunction

  // Number of set bits; W+1 wide so all-N-pending does not wrap.
  function automatic logic [W:0] popcount(input logic [N-1:0] vec);
    logic [W:0] cnt;
    cnt = {(W+1){1'b0}};
    for (int i = 0; i < N; i++) begin
      cnt = cnt + {{W{1'b0}}, vec[i]};
    end
    return cnt;
  endfunction

  assign handshake_s  = enc_valid_r && bus.enc_ready;
  assign grant_mask_s = handshake_s ? ({{(N-1){1'b0}}, 1'b1} << enc_out_r)
                                    : {N{1'b0}};

  // Next pending set and overflow: clear-all wins, otherwise retire the grant
  // and merge new requests (a re-request on the granted bit re-arms it).
  always_comb begin
    pending_next_s  = pending_r;
    overflow_next_s = 1'b0;
    if (bus.clr_all) begin
      pending_next_s  = {N{1'b0}};
      overflow_next_s = 1'b0;
    end else begin
      pending_next_s  = (pending_r & ~grant_mask_s) | bus.req_in;
      overflow_next_s = |(bus.req_in & pending_r & ~grant_mask_s);
    end
  end

`ifdef PENC_ROUND_ROBIN_EN
  logic [W-1:0] ptr_r;

  // Pointer advances past the granted index on each completed handshake.
  always_comb begin
    ptr_next_s = ptr_r;
    if (!bus.clr_all && handshake_s) begin
      ptr_next_s = (enc_out_r == W'(N - 1)) ? {W{1'b0}} : enc_out_r + W'(1);
    end else begin
      ptr_next_s = ptr_r;
    end
  end

  // Round-robin start pointer register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r <= {W{1'b0}};
    end else begin
      ptr_r <= ptr_next_s;
    end
  end
`else
  assign ptr_next_s = {W{1'b0}};
`endif

  // Pending state plus registered decode of the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_r    <= {N{1'b0}};
      enc_valid_r  <= 1'b0;
      enc_out_r    <= {W{1'b0}};
      pend_count_r <= {(W+1){1'b0}};
      overflow_r   <= 1'b0;
    end else begin
      pending_r    <= pending_next_s;
      enc_valid_r  <= |pending_next_s;
      enc_out_r    <= select_idx(pending_next_s, ptr_next_s);
      pend_count_r <= popcount(pending_next_s);
      overflow_r   <= overflow_next_s;
    end
  end

  assign bus.pending    = pending_r;
  assign bus.enc_valid  = enc_valid_r;
  assign bus.enc_out    = enc_out_r;
  assign bus.pend_count = pend_count_r;
  assign bus.overflow   = overflow_r;
endmodule

// File: tb/tb_pending_priority_encoder.sv
// Self-checking bench for pending_priority_encoder: N=4 and N=8 instances,
// table-driven directed vectors, a hand-written held-request sequence, and
// randomized stimulus against a behavioural model on the N=8 instance.
module tb_pending_priority_encoder;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  pending_priority_encoder_if #(.N(4)) b4 ();
  pending_priority_encoder_if #(.N(8)) b8 ();

  pending_priority_encoder #(.N(4)) u4 (.clk(clk), .rst(rst), .bus(b4.slave));
  pending_priority_encoder #(.N(8)) u8 (.clk(clk), .rst(rst), .bus(b8.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] req;
    logic       clr;
    logic       rdy;
    logic [7:0] pend;
    logic       vld;
    logic [2:0] out;
    logic [3:0] cnt;
    logic       ovf;
  } vec_t;

  vec_t t4[8];
  vec_t t8[14];

  // behavioural model state (N=8)
  bit m_pend[8];
  int m_ptr;
  bit m_ovf;

  task automatic chk(input string name, input int idx,
                     input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_row(input bit is4, input vec_t v, input int idx);
    if (is4) begin
      b4.req_in = v.req[3:0]; b4.clr_all = v.clr; b4.enc_ready = v.rdy;
    end else begin
      b8.req_in = v.req;      b8.clr_all = v.clr; b8.enc_ready = v.rdy;
    end
    tick();
    if (is4) begin
      chk("n4_pending", idx, 64'(b4.pending), 64'(v.pend));
      chk("n4_valid",   idx, 64'(b4.enc_valid), 64'(v.vld));
      chk("n4_out",     idx, 64'(b4.enc_out), 64'(v.out));
      chk("n4_count",   idx, 64'(b4.pend_count), 64'(v.cnt));
      chk("n4_ovf",     idx, 64'(b4.overflow), 64'(v.ovf));
    end else begin
      chk("n8_pending", idx, 64'(b8.pending), 64'(v.pend));
      chk("n8_valid",   idx, 64'(b8.enc_valid), 64'(v.vld));
      chk("n8_out",     idx, 64'(b8.enc_out), 64'(v.out));
      chk("n8_count",   idx, 64'(b8.pend_count), 64'(v.cnt));
      chk("n8_ovf",     idx, 64'(b8.overflow), 64'(v.ovf));
    end
  endtask

  // index the consumer would be offered from the model state, -1 if none
  function automatic int m_sel();
    for (int d = 0; d < 8; d++) begin
      if (m_pend[(m_ptr + d) % 8]) return (m_ptr + d) % 8;
    end
    return -1;
  endfunction

  task automatic m_step(input bit r, input bit c, input logic [7:0] q, input bit y);
    int sel;
    sel = m_sel();
    if (r) begin
      foreach (m_pend[i]) m_pend[i] = 1'b0;
      m_ptr = 0;
      m_ovf = 1'b0;
    end else if (c) begin
      foreach (m_pend[i]) m_pend[i] = 1'b0;
      m_ovf = 1'b0;
    end else begin
      m_ovf = 1'b0;
      for (int i = 0; i < 8; i++) begin
        bit granted;
        granted = y && (sel == i);
        if (q[i] && m_pend[i] && !granted) m_ovf = 1'b1;
        m_pend[i] = (m_pend[i] && !granted) || q[i];
      end
`ifdef PENC_ROUND_ROBIN_EN
      if (y && sel >= 0) m_ptr = (sel + 1) % 8;
`endif
    end
  endtask

  initial begin
    logic [7:0] exp_pend;
    int         exp_cnt;
    int         s;
    total = 0;
    bad   = 0;

    // N=4 one-hot replay of the legacy encoder
    t4[0] = '{8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 3'd0, 4'd1, 1'b0};
    t4[1] = '{8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 3'd0, 4'd0, 1'b0};
    t4[2] = '{8'h02, 1'b0, 1'b1, 8'h02, 1'b1, 3'd1, 4'd1, 1'b0};
    t4[3] = '{8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 3'd0, 4'd0, 1'b0};
    t4[4] = '{8'h04, 1'b0, 1'b1, 8'h04, 1'b1, 3'd2, 4'd1, 1'b0};
    t4[5] = '{8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 3'd0, 4'd0, 1'b0};
    t4[6] = '{8'h08, 1'b0, 1'b1, 8'h08, 1'b1, 3'd3, 4'd1, 1'b0};
    t4[7] = '{8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 3'd0, 4'd0, 1'b0};

    // N=8: priority order, backpressure/overflow, re-request, clear, merge
    t8[0]  = '{8'hA4, 1'b0, 1'b1, 8'hA4, 1'b1, 3'd2, 4'd3, 1'b0};
    t8[1]  = '{8'h00, 1'b0, 1'b1, 8'hA0, 1'b1, 3'd5, 4'd2, 1'b0};
    t8[2]  = '{8'h00, 1'b0, 1'b1, 8'h80, 1'b1, 3'd7, 4'd1, 1'b0};
    t8[3]  = '{8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 3'd0, 4'd0, 1'b0};
    t8[4]  = '{8'h01, 1'b0, 1'b0, 8'h01, 1'b1, 3'd0, 4'd1, 1'b0};
    t8[5]  = '{8'h01, 1'b0, 1'b0, 8'h01, 1'b1, 3'd0, 4'd1, 1'b1};
    t8[6]  = '{8'h00, 1'b0, 1'b0, 8'h01, 1'b1, 3'd0, 4'd1, 1'b0};
    t8[7]  = '{8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 3'd0, 4'd0, 1'b0};
    t8[8]  = '{8'h01, 1'b0, 1'b0, 8'h01, 1'b1, 3'd0, 4'd1, 1'b0};
    t8[9]  = '{8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 3'd0, 4'd1, 1'b0};
    t8[10] = '{8'h80, 1'b1, 1'b1, 8'h00, 1'b0, 3'd0, 4'd0, 1'b0};
    t8[11] = '{8'h06, 1'b0, 1'b1, 8'h06, 1'b1, 3'd1, 4'd2, 1'b0};
    t8[12] = '{8'h04, 1'b0, 1'b1, 8'h04, 1'b1, 3'd2, 4'd1, 1'b1};
    t8[13] = '{8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 3'd0, 4'd0, 1'b0};

    // reset held two cycles with all requests asserted
    rst = 1'b1;
    b4.req_in = 4'hF;  b4.clr_all = 1'b0; b4.enc_ready = 1'b1;
    b8.req_in = 8'hFF; b8.clr_all = 1'b0; b8.enc_ready = 1'b1;
    tick();
    tick();
    chk("rst4_pending", 0, 64'(b4.pending), 64'h0);
    chk("rst4_valid",   0, 64'(b4.enc_valid), 64'h0);
    chk("rst4_out",     0, 64'(b4.enc_out), 64'h0);
    chk("rst4_count",   0, 64'(b4.pend_count), 64'h0);
    chk("rst4_ovf",     0, 64'(b4.overflow), 64'h0);
    chk("rst8_pending", 0, 64'(b8.pending), 64'h0);
    chk("rst8_valid",   0, 64'(b8.enc_valid), 64'h0);
    rst = 1'b0;
    b4.req_in = 4'h0;
    b8.req_in = 8'h00;

    for (int i = 0; i < 8; i++)  run_row(1'b1, t4[i], i);
    for (int i = 0; i < 14; i++) run_row(1'b0, t8[i], i);

    // N=4 requests held high with ready high: rotation or fixed winner
    rst = 1'b1;
    b4.req_in = 4'h0;
    tick();
    rst = 1'b0;
    b4.req_in = 4'hF;
    b4.enc_ready = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      chk("hold_valid",   k, 64'(b4.enc_valid), 64'h1);
      chk("hold_pending", k, 64'(b4.pending), 64'hF);
`ifdef PENC_ROUND_ROBIN_EN
      chk("hold_rr_out",  k, 64'(b4.enc_out), 64'((k - 1) % 4));
`else
      chk("hold_fix_out", k, 64'(b4.enc_out), 64'h0);
`endif
      chk("hold_ovf",     k, 64'(b4.overflow), 64'(k > 1));
    end
    b4.req_in = 4'h0;

    // randomized stimulus on N=8 against the model
    m_ptr = 0;
    for (int k = 0; k < 400; k++) begin
      bit         r, c, y;
      logic [7:0] q;
      r = (k == 0) || ($urandom_range(0, 59) == 0);
      c = ($urandom_range(0, 24) == 0);
      y = ($urandom_range(0, 3) != 0);
      q = 8'($urandom & $urandom & $urandom);
      rst = r;
      b8.req_in = q; b8.clr_all = c; b8.enc_ready = y;
      m_step(r, c, q, y);
      tick();
      exp_pend = 8'h00;
      exp_cnt  = 0;
      for (int i = 0; i < 8; i++) begin
        exp_pend[i] = m_pend[i];
        exp_cnt += int'(m_pend[i]);
      end
      s = m_sel();
      chk("rnd_pending", k, 64'(b8.pending), 64'(exp_pend));
      chk("rnd_count",   k, 64'(b8.pend_count), 64'(exp_cnt));
      chk("rnd_valid",   k, 64'(b8.enc_valid), 64'(exp_cnt != 0));
      chk("rnd_out",     k, 64'(b8.enc_out), 64'((s < 0) ? 0 : s));
      chk("rnd_ovf",     k, 64'(b8.overflow), 64'(m_ovf));
    end
    rst = 1'b0;
    b8.req_in = 8'h00; b8.clr_all = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
